// File: rtl/fll_bus_arbiter.sv
// Round-robin arbiter sharing one FLL configuration bus.
// One outstanding transaction, captured command, registered response.
module fll_bus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      web_i,
  input  logic [4*NUM_REQ-1:0]    addr_i,
  input  logic [32*NUM_REQ-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]      ack_o,
  output logic [31:0]             rdata_o,
  output logic                    err_o,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic                    fll_req_o,
  output logic                    fll_web_o,
  output logic [3:0]              fll_addr_o,
  output logic [31:0]             fll_wdata_o,
  input  logic                    fll_ack_i,
  input  logic [31:0]             fll_rdata_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 0)
                    ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  logic [IW-1:0]        rr;
  logic [IW-1:0]        gnt_idx;
  logic [CW-1:0]        cnt;

  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic                 pick_web;
  logic [3:0]           pick_addr;
  logic [31:0]          pick_wdata;
  int                   j;

  // First requester at or above rr, wrapping; the lowest offset wins
  always_comb begin
    pick_vld   = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    pick_web   = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    j          = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_i[j]) begin
        pick_vld   = 1'b1;
        pick_idx   = IW'(j);
        pick_oh    = '0;
        pick_oh[j] = 1'b1;
        pick_web   = web_i[j];
        pick_addr  = addr_i[4*j +: 4];
        pick_wdata = wdata_i[32*j +: 32];
      end
    end
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      rr          <= '0;
      gnt_idx     <= '0;
      cnt         <= '0;
      ack_o       <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      grant_o     <= '0;
      fll_req_o   <= 1'b0;
      fll_web_o   <= 1'b0;
      fll_addr_o  <= '0;
      fll_wdata_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_o     <= pick_oh;
            gnt_idx     <= pick_idx;
            fll_web_o   <= pick_web;
            fll_addr_o  <= pick_addr;
            fll_wdata_o <= pick_wdata;
            fll_req_o   <= 1'b1;
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (fll_ack_i) begin
            rdata_o   <= fll_rdata_i;
            err_o     <= 1'b0;
            ack_o     <= grant_o;
            fll_req_o <= 1'b0;
            state     <= RESP;
          end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
            rdata_o   <= '0;
            err_o     <= 1'b1;
            ack_o     <= grant_o;
            fll_req_o <= 1'b0;
            state     <= RESP;
          end else if (TIMEOUT_CYC != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ack_o   <= '0;
          rdata_o <= '0;
          err_o   <= 1'b0;
          grant_o <= '0;
          rr      <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fll_bus_arbiter.sv
// Directed bench for fll_bus_arbiter, three requesters,
// eight-cycle ack timeout.
module tb_fll_bus_arbiter;

  localparam int N = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    web;
  logic [4*N-1:0]  addr;
  logic [32*N-1:0] wdata;
  logic [N-1:0]    ack;
  logic [31:0]     rdata;
  logic            err;
  logic [N-1:0]    grant;
  logic            f_req;
  logic            f_web;
  logic [3:0]      f_addr;
  logic [31:0]     f_wdata;
  logic            f_ack;
  logic [31:0]     f_rdata;

  int total = 0;
  int bad   = 0;

  fll_bus_arbiter #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .web_i      (web),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .ack_o      (ack),
    .rdata_o    (rdata),
    .err_o      (err),
    .grant_o    (grant),
    .fll_req_o  (f_req),
    .fll_web_o  (f_web),
    .fll_addr_o (f_addr),
    .fll_wdata_o(f_wdata),
    .fll_ack_i  (f_ack),
    .fll_rdata_i(f_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic w,
                         input logic [3:0] a,
                         input logic [31:0] d);
    web[i]          = w;
    addr[4*i +: 4]  = a;
    wdata[32*i +: 32] = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},   32'(f_req), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_ack"},   32'(ack),   32'd0);
    chk({tag, "_rdata"}, rdata,      32'd0);
    chk({tag, "_err"},   32'(err),   32'd0);
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    req     = '0;
    web     = '0;
    addr    = '0;
    wdata   = '0;
    f_ack   = 1'b0;
    f_rdata = '0;
    #12;
    chk_idle("rst");
    chk("rst_addr",  32'(f_addr), 32'd0);
    chk("rst_wdata", f_wdata,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T1 single write, FLL acks three cycles into BUSY
    set_cmd(0, 1'b0, 4'h2, 32'hA5A5_0001);
    req = 3'b001;
    step();
    chk("t1_req",   32'(f_req),  32'd1);
    chk("t1_grant", 32'(grant),  32'b001);
    chk("t1_web",   32'(f_web),  32'd0);
    chk("t1_addr",  32'(f_addr), 32'h2);
    chk("t1_wdata", f_wdata,     32'hA5A5_0001);
    step();
    chk("t1_hold_ack", 32'(ack), 32'd0);
    step();
    chk("t1_hold_req", 32'(f_req), 32'd1);
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    req   = '0;
    chk("t1_ack",   32'(ack),   32'b001);
    chk("t1_err",   32'(err),   32'd0);
    chk("t1_fdrop", 32'(f_req), 32'd0);
    step();
    chk_idle("t1_after");

    // T2 read from requester 1
    set_cmd(1, 1'b1, 4'h0, 32'h0);
    req = 3'b010;
    step();
    chk("t2_grant", 32'(grant), 32'b010);
    chk("t2_web",   32'(f_web), 32'd1);
    chk("t2_addr",  32'(f_addr), 32'h0);
    f_ack   = 1'b1;
    f_rdata = 32'h1234_5678;
    step();
    f_ack = 1'b0;
    req   = '0;
    chk("t2_ack",   32'(ack), 32'b010);
    chk("t2_rdata", rdata,    32'h1234_5678);
    chk("t2_err",   32'(err), 32'd0);
    step();
    chk_idle("t2_after");

    // T6 async reset while BUSY
    set_cmd(2, 1'b0, 4'h7, 32'h7777_0002);
    req = 3'b110;
    step();
    chk("t6_grant_pre", 32'(grant), 32'b100);
    chk("t6_req_pre",   32'(f_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req_rst",   32'(f_req), 32'd0);
    chk("t6_grant_rst", 32'(grant), 32'd0);
    chk("t6_ack_rst",   32'(ack),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_grant_post", 32'(grant), 32'b010);
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    req   = '0;
    chk("t6_ack", 32'(ack), 32'b010);
    step();

    // T3 fairness from a clean pointer
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    set_cmd(0, 1'b1, 4'h1, 32'h0);
    set_cmd(1, 1'b1, 4'h1, 32'h0);
    set_cmd(2, 1'b1, 4'h1, 32'h0);
    req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("t3_grant%0d", n), 32'(grant),
          32'(3'b001 << (n % 3)));
      chk($sformatf("t3_req%0d", n), 32'(f_req), 32'd1);
      f_ack   = 1'b1;
      f_rdata = 32'(n + 16);
      step();
      f_ack = 1'b0;
      chk($sformatf("t3_ack%0d", n), 32'(ack),
          32'(3'b001 << (n % 3)));
      chk($sformatf("t3_rd%0d", n), rdata, 32'(n + 16));
      chk($sformatf("t3_gap%0d", n), 32'(f_req), 32'd0);
      step();
      chk($sformatf("t3_idle%0d", n), 32'(f_req), 32'd0);
      if (n == 5) req = '0;
    end

    // T4 timeout with a late ack afterwards
    set_cmd(0, 1'b0, 4'h5, 32'h5555_5555);
    f_rdata = 32'hDEAD_BEEF;
    req = 3'b001;
    step();
    chk("t4_grant", 32'(grant), 32'b001);
    for (int c = 2; c <= 8; c++) begin
      step();
      chk($sformatf("t4_wait%0d", c), 32'(ack), 32'd0);
    end
    chk("t4_busy8", 32'(f_req), 32'd1);
    step();
    req = '0;
    chk("t4_ack",   32'(ack),   32'b001);
    chk("t4_err",   32'(err),   32'd1);
    chk("t4_rdata", rdata,      32'd0);
    chk("t4_fdrop", 32'(f_req), 32'd0);
    step();
    chk_idle("t4_after");
    step();
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    chk("t4_late_req", 32'(f_req), 32'd0);
    chk("t4_late_ack", 32'(ack),   32'd0);
    step();
    chk("t4_late_ack2", 32'(ack), 32'd0);

    // T5 ack on the timeout cycle wins
    set_cmd(1, 1'b1, 4'h3, 32'h0);
    req = 3'b010;
    step();
    chk("t5_grant", 32'(grant), 32'b010);
    for (int c = 2; c <= 8; c++) step();
    f_ack   = 1'b1;
    f_rdata = 32'hCAFE_F00D;
    step();
    f_ack = 1'b0;
    req   = '0;
    chk("t5_ack",   32'(ack), 32'b010);
    chk("t5_err",   32'(err), 32'd0);
    chk("t5_rdata", rdata,    32'hCAFE_F00D);
    step();
    chk_idle("t5_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
